pulse_stretcher: RTL

- Output-side counterpart to the button debouncer. The debouncer removes short glitches from board inputs; this block turns single-cycle game events (hit, miss, beat) into LED/buzzer pulses long enough to see or hear.
- Each event produces one blink: O is held high for ON_CYCLES, then a guaranteed low gap of GAP_CYCLES.
- Events arriving while a blink is in progress are queued in a saturating counter, so each one still produces a distinct blink.
- Sits between game logic and the board LED/buzzer pins, one instance per output.

---
 rtl/cm_pkg.sv | 10 +
 rtl/stretch_timer.sv | 27 ++
 rtl/pulse_stretcher.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cm_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding.
package cm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/stretch_timer.sv
// Loadable down-counter shared by the ON and GAP phases; holds at zero.
module stretch_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into visible blinks (ON_CYCLES high, GAP_CYCLES low),
// queueing events that arrive mid-blink in a saturating counter.
module pulse_stretcher
    import cm_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int ON_CYCLES  = 1000000,
    parameter int GAP_CYCLES = 250000,
    parameter int PEND_MAX   = 3,
    parameter int PEND_W     = 2,
    parameter int RETRIG     = 0,
    parameter int EDGE       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I,
    output logic              O,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              drop
);

    localparam logic [CNT_W-1:0]  ON_LD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] P_MAX  = PEND_W'(PEND_MAX);

    state_e            state_q, state_d;
    logic              o_q, o_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              i_q;
    logic              ev;
    logic              zero;
    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              en;
    logic              inc, dec;

    assign ev = (EDGE != 0) ? (I & ~i_q) : I;

    stretch_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .zero     (zero)
    );

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        load     = 1'b0;
        load_val = ON_LD;
        en       = 1'b0;
        inc      = 1'b0;
        dec      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ev) begin
                    state_d = ST_ON;
                    o_d     = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_ON: begin
                inc = ev && (RETRIG == 0);
                if (ev && (RETRIG != 0)) begin
                    load = 1'b1;
                end else if (zero) begin
                    state_d  = ST_GAP;
                    o_d      = 1'b0;
                    load     = 1'b1;
                    load_val = GAP_LD;
                end else begin
                    en = 1'b1;
                end
            end
            ST_GAP: begin
                if (zero) begin
                    if ((pend_q != '0) || ev) begin
                        state_d = ST_ON;
                        o_d     = 1'b1;
                        load    = 1'b1;
                        // A fresh event with an empty queue starts the blink directly.
                        dec     = (pend_q != '0);
                        inc     = ev && (pend_q != '0);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    en  = 1'b1;
                    inc = ev;
                end
            end
            default: begin
                state_d = ST_IDLE;
                o_d     = 1'b0;
            end
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        drop_d = 1'b0;
        if (inc && !dec) begin
            if (pend_q == P_MAX) begin
                drop_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - 1'b1;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            pend_q  <= '0;
            i_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
            i_q     <= I;
        end
    end

    assign O    = o_q;
    assign busy = busy_q;
    assign pend = pend_q;
    assign drop = drop_q;

endmodule
